// File: rtl/counter_seq_pkg.sv
// Shared opcodes, FSM state codes and CONFIG field layout for counter_sequencer.
package counter_seq_pkg;

    localparam logic [1:0] OP_CONFIG = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PULSE_HI = 2'd1;
    localparam logic [1:0] ST_PULSE_LO = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int CFG_MAX_VAL_LSB = 0;
    localparam int CFG_MAX_VAL_MSB = 3;
    localparam int CFG_MAX_EN      = 4;
    localparam int CFG_UP_DOWN     = 5;
    localparam int CFG_CARRY_EN    = 6;
    localparam int CFG_CARRY_IN    = 7;

    typedef struct packed {
        logic       carry_in;
        logic       carry_en;
        logic       up_down_sel;
        logic       max_en;
        logic [3:0] max_val;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [7:0] arg);
        cfg_t c;
        c.max_val     = arg[CFG_MAX_VAL_MSB:CFG_MAX_VAL_LSB];
        c.max_en      = arg[CFG_MAX_EN];
        c.up_down_sel = arg[CFG_UP_DOWN];
        c.carry_en    = arg[CFG_CARRY_EN];
        c.carry_in    = arg[CFG_CARRY_IN];
        return c;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_shaper.sv
// HIGH/LOW phase timer: drives a registered inc pulse and strobes the last
// cycle of each phase so the sequencer can chain or stop pulses.
module pulse_shaper #(
    parameter int unsigned PULSE_HIGH = 2,
    parameter int unsigned PULSE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic kill,
    output logic inc,
    output logic hi_end,
    output logic pulse_end
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_HIGH = 2'd1;
    localparam logic [1:0] PH_LOW  = 2'd2;

    localparam logic [7:0] HIGH_LOAD = 8'(PULSE_HIGH - 1);
    localparam logic [7:0] LOW_LOAD  = 8'(PULSE_LOW - 1);

    logic [1:0] phase_q, phase_d;
    logic [7:0] timer_q, timer_d;
    logic       inc_q, inc_d;
    logic       timer_tc;

    assign timer_tc = (timer_q == 8'd0);

    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        if (kill) begin
            phase_d = PH_IDLE;
            timer_d = 8'd0;
        end else if (fire) begin
            phase_d = PH_HIGH;
            timer_d = HIGH_LOAD;
        end else begin
            case (phase_q)
                PH_HIGH: begin
                    if (timer_tc) begin
                        phase_d = PH_LOW;
                        timer_d = LOW_LOAD;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                PH_LOW: begin
                    if (timer_tc) begin
                        phase_d = PH_IDLE;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
        // inc is its own flop so the counter sees a clean edge, not a state decode
        inc_d = (phase_d == PH_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            timer_q <= 8'd0;
            inc_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            inc_q   <= inc_d;
        end
    end

    assign inc       = inc_q;
    assign hi_end    = (phase_q == PH_HIGH) && timer_tc;
    assign pulse_end = (phase_q == PH_LOW) && timer_tc;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller that configures a counter, issues shaped inc
// pulses (STEP / RUN_TO_CARRY) and counts carry_out wraps.
//
// state       | meaning
// ST_IDLE     | ready for a command
// ST_PULSE_HI | inc pulse high phase
// ST_PULSE_LO | inc pulse low phase; pulse bookkeeping at its last cycle
// ST_DONE     | one-cycle completion, done=1
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned PULSE_HIGH = 2,
    parameter int unsigned PULSE_LOW  = 1,
    parameter int unsigned MAX_PULSES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    input  logic       abort,
    input  logic       cnt_carry_out,
    output logic       cnt_inc,
    output logic       cnt_up_down_sel,
    output logic       cnt_carry_en,
    output logic       cnt_carry_in,
    output logic       cnt_max_en,
    output logic [3:0] cnt_max_val,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] wrap_count
);

    localparam logic [7:0] MAX_PULSES_8 = 8'(MAX_PULSES);

    logic [1:0] state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] pulses_q, pulses_d;
    logic       run_mode_q, run_mode_d;
    logic       carry_seen_q, carry_seen_d;
    logic       prev_carry_q;
    logic       timeout_q, timeout_d;
    logic [7:0] wrap_q, wrap_d;
    cfg_t       cfg_q, cfg_d;

    logic carry_edge;
    logic in_pulse;
    logic fire;
    logic kill;
    logic hi_end;
    logic pulse_end;
    logic inc;

    assign carry_edge = cnt_carry_out & ~prev_carry_q;
    assign in_pulse   = (state_q == ST_PULSE_HI) || (state_q == ST_PULSE_LO);

    pulse_shaper #(
        .PULSE_HIGH(PULSE_HIGH),
        .PULSE_LOW (PULSE_LOW)
    ) u_shaper (
        .clk      (clk),
        .rst_n    (reset),
        .fire     (fire),
        .kill     (kill),
        .inc      (inc),
        .hi_end   (hi_end),
        .pulse_end(pulse_end)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pulses_d     = pulses_q;
        run_mode_d   = run_mode_q;
        carry_seen_d = carry_seen_q;
        timeout_d    = timeout_q;
        cfg_d        = cfg_q;
        wrap_d       = carry_edge ? sat_inc8(wrap_q) : wrap_q;
        fire         = 1'b0;
        kill         = 1'b0;

        if (in_pulse && carry_edge) begin
            carry_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    timeout_d = 1'b0;
                    case (cmd_op)
                        OP_CONFIG: begin
                            cfg_d   = decode_cfg(cmd_arg);
                            wrap_d  = 8'd0;
                            state_d = ST_DONE;
                        end
                        OP_STEP: begin
                            if (cmd_arg == 8'd0) begin
                                state_d = ST_DONE;
                            end else begin
                                remaining_d = cmd_arg;
                                run_mode_d  = 1'b0;
                                fire        = 1'b1;
                                state_d     = ST_PULSE_HI;
                            end
                        end
                        OP_RUN: begin
                            pulses_d   = 8'd0;
                            run_mode_d = 1'b1;
                            fire       = 1'b1;
                            state_d    = ST_PULSE_HI;
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_PULSE_HI: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = ST_DONE;
                end else if (hi_end) begin
                    state_d = ST_PULSE_LO;
                end
            end
            ST_PULSE_LO: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = ST_DONE;
                end else if (pulse_end) begin
                    if (run_mode_q) begin
                        pulses_d = pulses_q + 8'd1;
                        // an edge in this very cycle still belongs to the pulse just ending
                        if (carry_seen_q || carry_edge) begin
                            state_d = ST_DONE;
                        end else if (pulses_q + 8'd1 == MAX_PULSES_8) begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            fire    = 1'b1;
                            state_d = ST_PULSE_HI;
                        end
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                        if (remaining_q == 8'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            fire    = 1'b1;
                            state_d = ST_PULSE_HI;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fire) begin
            carry_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 8'd0;
            pulses_q     <= 8'd0;
            run_mode_q   <= 1'b0;
            carry_seen_q <= 1'b0;
            prev_carry_q <= 1'b0;
            timeout_q    <= 1'b0;
            wrap_q       <= 8'd0;
            cfg_q        <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pulses_q     <= pulses_d;
            run_mode_q   <= run_mode_d;
            carry_seen_q <= carry_seen_d;
            prev_carry_q <= cnt_carry_out;
            timeout_q    <= timeout_d;
            wrap_q       <= wrap_d;
            cfg_q        <= cfg_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign timeout         = timeout_q;
    assign wrap_count      = wrap_q;
    assign cnt_inc         = inc;
    assign cnt_up_down_sel = cfg_q.up_down_sel;
    assign cnt_carry_en    = cfg_q.carry_en;
    assign cnt_carry_in    = cfg_q.carry_in;
    assign cnt_max_en      = cfg_q.max_en;
    assign cnt_max_val     = cfg_q.max_val;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random traffic checked
// each cycle against a pulse-timeline model of the command semantics.
module tb_counter_sequencer;

    localparam int PH   = 2;
    localparam int PL   = 1;
    localparam int P    = PH + PL;
    localparam int MAXP = 5;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [7:0] cmd_arg   = 8'h00;
    logic       abort     = 1'b0;
    logic       cnt_carry_out;
    logic       cmd_ready, cnt_inc, cnt_up_down_sel, cnt_carry_en, cnt_carry_in, cnt_max_en;
    logic [3:0] cnt_max_val;
    logic       busy, done, timeout;
    logic [7:0] wrap_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(
        .PULSE_HIGH(PH),
        .PULSE_LOW (PL),
        .MAX_PULSES(MAXP)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .abort          (abort),
        .cnt_carry_out  (cnt_carry_out),
        .cnt_inc        (cnt_inc),
        .cnt_up_down_sel(cnt_up_down_sel),
        .cnt_carry_en   (cnt_carry_en),
        .cnt_carry_in   (cnt_carry_in),
        .cnt_max_en     (cnt_max_en),
        .cnt_max_val    (cnt_max_val),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .wrap_count     (wrap_count)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // carry source: 0 tied low, 1 small up-counter stub, 2 random
    int         cmode     = 0;
    logic       rnd_carry = 1'b0;
    logic       stub_carry = 1'b0;
    logic [3:0] stub_val   = 4'd0;
    logic       stub_prev_inc = 1'b0;

    assign cnt_carry_out = (cmode == 1) ? stub_carry : (cmode == 2) ? rnd_carry : 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_val <= 4'd0; stub_carry <= 1'b0; stub_prev_inc <= 1'b0;
        end else begin
            stub_prev_inc <= cnt_inc;
            stub_carry    <= 1'b0;
            if (cmode != 1) begin
                stub_val <= 4'd0;
            end else if (cnt_inc && !stub_prev_inc) begin
                if ((cnt_max_en && stub_val == cnt_max_val) || stub_val == 4'hF) begin
                    stub_val <= 4'd0; stub_carry <= 1'b1;
                end else begin
                    stub_val <= stub_val + 4'd1;
                end
            end
        end
    end

    // Reference model: a command is a train of P-cycle pulse periods counted
    // from the cycle after accept; the first PH cycles of each period are high.
    bit         m_active = 0, m_done = 0, m_run = 0, m_seen = 0, m_prev = 0, m_timeout = 0;
    int         m_k = 0, m_n = 0;
    logic [7:0] m_wrap = 8'd0;
    logic [7:0] m_cfg  = 8'd0;
    bit         m_ce;
    int         m_off, m_pno;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_run = 0; m_seen = 0; m_prev = 0; m_timeout = 0;
            m_k = 0; m_n = 0; m_wrap = 8'd0; m_cfg = 8'd0;
        end else begin
            m_ce   = cnt_carry_out && !m_prev;
            m_prev = cnt_carry_out;
            if (m_ce && m_wrap != 8'hFF) m_wrap = m_wrap + 8'd1;
            if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (cmd_valid) begin
                    m_timeout = 0;
                    case (cmd_op)
                        2'b00: begin m_cfg = cmd_arg; m_wrap = 8'd0; m_done = 1; end
                        2'b01: begin
                            if (cmd_arg == 8'd0) m_done = 1;
                            else begin m_active = 1; m_run = 0; m_n = int'(cmd_arg); m_k = 0; end
                        end
                        2'b10: begin m_active = 1; m_run = 1; m_k = 0; end
                        default: m_done = 1;
                    endcase
                end
            end else begin
                m_off  = m_k % P;
                m_seen = ((m_off == 0) ? 1'b0 : m_seen) | m_ce;
                if (abort) begin
                    m_active = 0; m_done = 1;
                end else if (m_off == P - 1) begin
                    m_pno = m_k / P + 1;
                    if (m_run) begin
                        if (m_seen) begin m_active = 0; m_done = 1; end
                        else if (m_pno == MAXP) begin m_timeout = 1; m_active = 0; m_done = 1; end
                    end else if (m_pno == m_n) begin
                        m_active = 0; m_done = 1;
                    end
                end
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cnt_inc",   32'(cnt_inc),   32'(m_active && (m_k % P) < PH));
            chk("busy",      32'(busy),      32'(m_active || m_done));
            chk("done",      32'(done),      32'(m_done));
            chk("cmd_ready", 32'(cmd_ready), 32'(!(m_active || m_done)));
            chk("timeout",   32'(timeout),   32'(m_timeout));
            chk("wrap",      32'(wrap_count), 32'(m_wrap));
            chk("cfg",       32'({cnt_carry_in, cnt_carry_en, cnt_up_down_sel, cnt_max_en, cnt_max_val}),
                             32'(m_cfg));
        end
    end

    int   cyc = 0;
    int   done_cyc = -1;
    int   pulse_cnt = 0;
    logic prev_inc_s = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) done_cyc = cyc;
        if (cnt_inc && !prev_inc_s) pulse_cnt++;
        prev_inc_s = cnt_inc;
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("ready_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] arg, output int acc);
        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        acc = cyc; pulse_cnt = 0; done_cyc = -1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 8'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cyc < 0 && n < 3000) begin @(negedge clk); n++; end
        if (done_cyc < 0) chk(nm, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_outs",  32'({cnt_inc, busy, done, timeout, cnt_max_en, cnt_max_val, wrap_count}), 32'd0);
        rst_n = 1'b1;

        send(2'b00, 8'h38, acc);
        wait_done("cfg_done_wait");
        chk("cfg_done_cyc", 32'(done_cyc), 32'(acc + 1));
        chk("cfg_max_val",  32'(cnt_max_val), 32'd8);
        chk("cfg_bits",     32'({cnt_max_en, cnt_up_down_sel, cnt_carry_en, cnt_carry_in}), 32'b1100);
        chk("cfg_wrap",     32'(wrap_count), 32'd0);

        send(2'b01, 8'd3, acc);
        while (cyc <= acc + 10) begin
            chk("step3_ready_low", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        chk("step3_ready_back", 32'(cmd_ready), 32'd1);
        chk("step3_done_cyc",   32'(done_cyc), 32'(acc + 10));
        chk("step3_pulses",     32'(pulse_cnt), 32'd3);

        send(2'b01, 8'd0, acc);
        wait_done("step0_done_wait");
        chk("step0_done_cyc", 32'(done_cyc), 32'(acc + 1));
        chk("step0_pulses",   32'(pulse_cnt), 32'd0);

        send(2'b00, 8'h33, acc);
        wait_done("cfg33_done_wait");
        cmode = 1;
        send(2'b10, 8'h00, acc);
        wait_done("run_carry_wait");
        chk("run_carry_done_cyc", 32'(done_cyc), 32'(acc + 13));
        chk("run_carry_pulses",   32'(pulse_cnt), 32'd4);
        chk("run_carry_wrap",     32'(wrap_count), 32'd1);
        chk("run_carry_timeout",  32'(timeout), 32'd0);

        cmode = 0;
        send(2'b10, 8'h00, acc);
        wait_done("run_to_wait");
        chk("run_to_done_cyc", 32'(done_cyc), 32'(acc + 1 + MAXP * P));
        chk("run_to_pulses",   32'(pulse_cnt), 32'(MAXP));
        chk("run_to_timeout",  32'(timeout), 32'd1);
        send(2'b01, 8'd1, acc);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        wait_done("step1_wait");

        send(2'b01, 8'd4, acc);
        while (cyc < acc + 4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_inc",  32'(cnt_inc), 32'd0);
        @(negedge clk);
        chk("abort_pulses", 32'(pulse_cnt), 32'd2);

        @(negedge clk);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd2; acc = cyc;
        @(negedge clk);
        while (cyc <= acc + 7) begin
            chk("held_ready_low", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        chk("held_ready_idle", 32'(cmd_ready), 32'd1);
        done_cyc = -1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_reaccept_busy", 32'(busy), 32'd1);
        wait_done("held_done_wait");
        chk("held_done_cyc", 32'(done_cyc), 32'(acc + 15));

        send(2'b01, 8'd5, acc);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_inc",  32'(cnt_inc), 32'd0);
        chk("midrst_busy", 32'({busy, done, timeout, wrap_count, cnt_max_val}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cmode = 2;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom % 3 == 0);
            cmd_op    = 2'($urandom);
            cmd_arg   = (cmd_op == 2'b01) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            abort     = ($urandom % 25 == 0);
            rnd_carry = ($urandom % 4 == 0);
        end
        cmd_valid = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Command-driven controller that sequences and configures one `counter` instance.
- Accepts commands over a valid/ready handshake: CONFIG, STEP and RUN_TO_CARRY.
- Drives the counter's control inputs, including shaped `inc` pulses, and monitors `carry_out` to count wraps.
- Sits between the project's control logic (or pin interface) and the counter datapath, replacing free-running stimulus on `inc`.

Parameters:
- PULSE_HIGH, 2: cycles `cnt_inc` is held high per increment pulse (>=1).
- PULSE_LOW, 1: cycles `cnt_inc` is held low after each pulse (>=1).
- MAX_PULSES, 255: pulse limit for RUN_TO_CARRY before timeout (<=255).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 CONFIG, 01 STEP, 10 RUN_TO_CARRY, 11 reserved (accepted, treated as no-op).
- cmd_arg  in  8  CONFIG: [3:0] max_val, [4] max_en, [5] up_down_sel, [6] carry_en, [7] carry_in. STEP: pulse count N. RUN_TO_CARRY: ignored.
- abort  in  1  terminate the active STEP/RUN_TO_CARRY.
- cnt_carry_out  in  1  `carry_out` from the counter.
- cnt_inc  out  1  to counter `inc`.
- cnt_up_down_sel  out  1  to counter `up_down_sel`.
- cnt_carry_en  out  1  to counter `carry_en`.
- cnt_carry_in  out  1  to counter `carry_in`.
- cnt_max_en  out  1  to counter `max_en`.
- cnt_max_val  out  4  to counter `max_val`.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- timeout  out  1  set when RUN_TO_CARRY hit MAX_PULSES; cleared on next accept.
- wrap_count  out  8  rising edges seen on `cnt_carry_out`, saturating.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All `cnt_*` outputs 0, `busy`=0, `done`=0, `timeout`=0, `wrap_count`=0.
  - Carry edge register 0.
- States: IDLE, PULSE_HI, PULSE_LO, DONE.
- Handshake:
  - `cmd_ready` = (state==IDLE), combinational from state.
  - A command is accepted on a rising edge with `cmd_valid` & `cmd_ready`.
  - `cmd_op` and `cmd_arg` are sampled only at the accept edge.
- CONFIG:
  - At the accept edge, load the config registers from `cmd_arg`, clear `wrap_count` and go to DONE.
  - `done`=1 in accept+1, then IDLE.
- STEP, N>0:
  - Load remaining=N and go to PULSE_HI.
  - PULSE_HI: `cnt_inc`=1 for PULSE_HIGH cycles. PULSE_LO: `cnt_inc`=0 for PULSE_LOW cycles.
  - At the end of PULSE_LO, decrement remaining. If it is 0, go to DONE; otherwise go to PULSE_HI.
  - `done` is asserted in cycle accept+1+N*(PULSE_HIGH+PULSE_LOW).
- STEP, N=0: go directly to DONE; no pulse is issued.
- RUN_TO_CARRY:
  - Pulses as for STEP, counting pulses issued.
  - At the end of each PULSE_LO:
    - If a `cnt_carry_out` rising edge occurred during that pulse period, go to DONE.
    - Else, if pulses==MAX_PULSES, set `timeout`=1 and go to DONE.
- Carry edge detection:
  - prev_carry is registered every cycle.
  - Edge = `cnt_carry_out` & ~prev_carry.
  - `wrap_count` increments on each edge in any state, saturating at 255.
  - Edges during CONFIG's accept edge are lost (clear wins).
- abort:
  - While in PULSE_HI or PULSE_LO, the next edge goes to DONE with `cnt_inc`=0; no partial-count correction is made.
  - Ignored in IDLE and DONE.
- `busy` = state in {PULSE_HI, PULSE_LO, DONE}.
- `cnt_inc` is registered and glitch-free; the config outputs change only on a CONFIG accept.
- `cnt_inc` is never high in IDLE or DONE.
- Reset asserted mid-command returns everything to the reset values immediately.

Decomposition:
- Package counter_seq_pkg holds:
  - opcode constants OP_CONFIG=2'b00, OP_STEP=2'b01, OP_RUN=2'b10;
  - state encoding constants;
  - CONFIG bit-field index constants.
- One natural sub-module, `pulse_shaper`: a HIGH/LOW phase timer that emits a `cnt_inc` pulse and a `pulse_end` strobe. The FSM and counters stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles → all outputs 0, `cmd_ready`=1. Pulse reset=0 mid-STEP → `cnt_inc`=0 and `busy`=0 at once.
- CONFIG with `cmd_arg`=8'h38 → `cnt_max_val`=8, `cnt_max_en`=1, `cnt_up_down_sel`=1, `cnt_carry_en`=0, `cnt_carry_in`=0; `done` in accept+1; `wrap_count`=0.
- STEP N=3 with defaults → 3 pulses of 2 high/1 low; `done` at accept+10; `cmd_ready`=0 for accept+1..accept+10. STEP N=0 → `done` at accept+1 with no pulse.
- RUN_TO_CARRY with the counter configured max_en=1, max_val=3, counting up from 0 → stops after the pulse in which the carry rises; `wrap_count`=1, `timeout`=0.
- RUN_TO_CARRY with MAX_PULSES=5 and carry tied 0 → 5 pulses, then `timeout`=1 and `done`=1. A following STEP accept clears `timeout`.
- abort asserted in the 2nd PULSE_HI of STEP N=4 → `done` next cycle, `cnt_inc` low, 2 pulses observed in total. cmd_valid held during a busy command → not accepted until IDLE.
